// File: rtl/band_dispatcher_if.sv
// Handshake bundle for band_dispatcher: configuration, raw sample input,
// first-band and next-band output streams. slave = dispatcher, master = env.
interface band_dispatcher_if #(
    parameter int DATA_WIDTH          = 16,
    parameter int BLOCK_WIDTH_LOG_MAX = 4,
    parameter int BAND_COUNT_WIDTH    = 8
);
    logic                           cfg_valid;
    logic                           cfg_ready;
    logic [BLOCK_WIDTH_LOG_MAX-1:0] cfg_width_m1;
    logic [BLOCK_WIDTH_LOG_MAX-1:0] cfg_height_m1;
    logic [BAND_COUNT_WIDTH-1:0]    cfg_bands_m1;

    logic                           x_valid;
    logic                           x_ready;
    logic [DATA_WIDTH-1:0]          x_data;

    logic                           fb_valid;
    logic                           fb_ready;
    logic [DATA_WIDTH-1:0]          fb_data;
    logic                           fb_last_row;
    logic                           fb_last_slice;

    logic                           nb_valid;
    logic                           nb_ready;
    logic [DATA_WIDTH-1:0]          nb_data;
    logic                           nb_last_row;
    logic                           nb_last_slice;
    logic                           nb_last_block;

    modport slave (
        input  cfg_valid, cfg_width_m1, cfg_height_m1, cfg_bands_m1,
        output cfg_ready,
        input  x_valid, x_data,
        output x_ready,
        output fb_valid, fb_data, fb_last_row, fb_last_slice,
        input  fb_ready,
        output nb_valid, nb_data, nb_last_row, nb_last_slice, nb_last_block,
        input  nb_ready
    );

    modport master (
        output cfg_valid, cfg_width_m1, cfg_height_m1, cfg_bands_m1,
        input  cfg_ready,
        output x_valid, x_data,
        input  x_ready,
        input  fb_valid, fb_data, fb_last_row, fb_last_slice,
        output fb_ready,
        input  nb_valid, nb_data, nb_last_row, nb_last_slice, nb_last_block,
        output nb_ready
    );
endinterface

// File: rtl/band_dispatcher.sv
// Band-sequential sample dispatcher: band 0 to fb port, later bands to nb,
// with row/slice/block end tags. Ports: clk, rst, bus (slave), busy, block_done.
module band_dispatcher #(
    parameter int DATA_WIDTH          = 16,
    parameter int BLOCK_WIDTH_LOG_MAX = 4,
    parameter int BAND_COUNT_WIDTH    = 8
) (
    input  logic             clk,
    input  logic             rst,
    band_dispatcher_if.slave bus,
    output logic             busy,
    output logic             block_done
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        NEXT  = 2'd2
    } state_t;

    state_t state, state_n;

    logic [BLOCK_WIDTH_LOG_MAX-1:0] col, row;
    logic [BLOCK_WIDTH_LOG_MAX-1:0] width_m1, height_m1;
    logic [BAND_COUNT_WIDTH-1:0]    band, bands_m1;

    logic [DATA_WIDTH-1:0] pass_data;
    logic last_row, last_slice, last_band, x_hs;

    assign pass_data  = bus.x_data;
    assign last_row   = (col == width_m1);
    assign last_slice = last_row && (row == height_m1);
    assign last_band  = (band == bands_m1);
    assign x_hs       = bus.x_valid && bus.x_ready;
    assign busy       = (state != IDLE);

    // Data and tags are driven unconditionally; consumers qualify by valid.
    assign bus.fb_data       = pass_data;
    assign bus.fb_last_row   = last_row;
    assign bus.fb_last_slice = last_slice;
    assign bus.nb_data       = pass_data;
    assign bus.nb_last_row   = last_row;
    assign bus.nb_last_slice = last_slice;
    assign bus.nb_last_block = last_slice && last_band;

    always_comb begin
        state_n       = state;
        bus.cfg_ready = 1'b0;
        bus.x_ready   = 1'b0;
        bus.fb_valid  = 1'b0;
        bus.nb_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                bus.cfg_ready = 1'b1;
                if (bus.cfg_valid)
                    state_n = FIRST;
            end
            FIRST: begin
                bus.fb_valid = bus.x_valid;
                bus.x_ready  = bus.fb_ready;
                if (x_hs && last_slice)
                    state_n = (bands_m1 != '0) ? NEXT : IDLE;
            end
            NEXT: begin
                bus.nb_valid = bus.x_valid;
                bus.x_ready  = bus.nb_ready;
                if (x_hs && last_slice && last_band)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            band       <= '0;
            width_m1   <= '0;
            height_m1  <= '0;
            bands_m1   <= '0;
            block_done <= 1'b0;
        end else begin
            // In FIRST with a single band, band==bands_m1==0, so this
            // covers both ways a block can finish.
            block_done <= x_hs && last_slice && last_band;
            if (state == IDLE && bus.cfg_valid) begin
                width_m1  <= bus.cfg_width_m1;
                height_m1 <= bus.cfg_height_m1;
                bands_m1  <= bus.cfg_bands_m1;
                col       <= '0;
                row       <= '0;
                band      <= '0;
            end else if (x_hs) begin
                if (last_row) begin
                    col <= '0;
                    if (last_slice) begin
                        row  <= '0;
                        band <= band + BAND_COUNT_WIDTH'(1);
                    end else begin
                        row <= row + BLOCK_WIDTH_LOG_MAX'(1);
                    end
                end else begin
                    col <= col + BLOCK_WIDTH_LOG_MAX'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_band_dispatcher.sv
// Directed self-checking bench for band_dispatcher.
// Drives at negedge, checks 1ns later, handshakes complete at posedge.
module tb_band_dispatcher;
    localparam int DW = 16;
    localparam int BW = 4;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic block_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    band_dispatcher_if #(
        .DATA_WIDTH(DW), .BLOCK_WIDTH_LOG_MAX(BW), .BAND_COUNT_WIDTH(CW)
    ) bus ();

    band_dispatcher #(
        .DATA_WIDTH(DW), .BLOCK_WIDTH_LOG_MAX(BW), .BAND_COUNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .busy(busy),
        .block_done(block_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Streams samples 0..n-1 of a w x h x b block; expected routing and
    // tags come from the sample index alone.
    task automatic run_block(input int w, input int h, input int b,
                             input int n, input bit stall,
                             input bit hold, input bit skip_cfg);
        int col, row, band, nb_hold;
        bit lr, ls, lb, done;
        logic [DW-1:0] d;
        nb_hold = 5;
        if (!skip_cfg) begin
            @(negedge clk);
            bus.cfg_valid     = 1'b1;
            bus.cfg_width_m1  = BW'(w - 1);
            bus.cfg_height_m1 = BW'(h - 1);
            bus.cfg_bands_m1  = CW'(b - 1);
            #1;
            chk("cfg_ready_idle", 32'(bus.cfg_ready), 1);
            chk("busy_idle", 32'(busy), 0);
        end
        for (int i = 0; i < n; i++) begin
            col  = i % w;
            row  = (i / w) % h;
            band = i / (w * h);
            lr   = (col == w - 1);
            ls   = lr && (row == h - 1);
            lb   = ls && (band == b - 1);
            d    = DW'(i) ^ 16'h5a00;
            done = 1'b0;
            for (int t = 0; t < 40 && !done; t++) begin
                @(negedge clk);
                if (!hold) bus.cfg_valid = 1'b0;
                cyc++;
                bus.x_valid = 1'b1;
                bus.x_data  = d;
                if (stall) begin
                    bus.fb_ready = cyc[0];
                    bus.nb_ready = !(band > 0 && nb_hold > 0);
                    if (band > 0 && nb_hold > 0) nb_hold--;
                end else begin
                    bus.fb_ready = 1'b1;
                    bus.nb_ready = 1'b1;
                end
                #1;
                chk("busy", 32'(busy), 1);
                chk("cfg_ready_busy", 32'(bus.cfg_ready), 0);
                chk("fb_valid", 32'(bus.fb_valid), 32'(band == 0));
                chk("nb_valid", 32'(bus.nb_valid), 32'(band != 0));
                chk("x_ready", 32'(bus.x_ready),
                    32'(band == 0 ? bus.fb_ready : bus.nb_ready));
                if (bus.x_ready) begin
                    done = 1'b1;
                    if (band == 0) begin
                        chk("fb_data", 32'(bus.fb_data), 32'(d));
                        chk("fb_last_row", 32'(bus.fb_last_row), 32'(lr));
                        chk("fb_last_slice", 32'(bus.fb_last_slice),
                            32'(ls));
                    end else begin
                        chk("nb_data", 32'(bus.nb_data), 32'(d));
                        chk("nb_last_row", 32'(bus.nb_last_row), 32'(lr));
                        chk("nb_last_slice", 32'(bus.nb_last_slice),
                            32'(ls));
                        chk("nb_last_block", 32'(bus.nb_last_block),
                            32'(lb));
                    end
                end
            end
            chk("handshake", 32'(done), 1);
        end
        if (n == w * h * b) begin
            @(negedge clk);
            bus.x_valid = 1'b0;
            #1;
            chk("block_done", 32'(block_done), 1);
            chk("busy_end", 32'(busy), 0);
            chk("cfg_ready_end", 32'(bus.cfg_ready), 1);
            chk("fb_valid_end", 32'(bus.fb_valid), 0);
            chk("nb_valid_end", 32'(bus.nb_valid), 0);
        end
    endtask

    initial begin
        rst               = 1'b1;
        bus.cfg_valid     = 1'b0;
        bus.cfg_width_m1  = '0;
        bus.cfg_height_m1 = '0;
        bus.cfg_bands_m1  = '0;
        bus.x_valid       = 1'b0;
        bus.x_data        = '0;
        bus.fb_ready      = 1'b1;
        bus.nb_ready      = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_block_done", 32'(block_done), 0);
        chk("rst_cfg_ready", 32'(bus.cfg_ready), 1);
        chk("rst_x_ready", 32'(bus.x_ready), 0);
        chk("rst_fb_valid", 32'(bus.fb_valid), 0);
        chk("rst_nb_valid", 32'(bus.nb_valid), 0);
        chk("rst_col", 32'(dut.col), 0);
        chk("rst_band", 32'(dut.band), 0);
        rst = 1'b0;

        run_block(4, 4, 3, 48, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("block_done_pulse", 32'(block_done), 0);

        run_block(16, 16, 1, 256, 1'b0, 1'b0, 1'b0);
        run_block(1, 1, 4, 4, 1'b0, 1'b0, 1'b0);
        run_block(4, 4, 2, 32, 1'b1, 1'b0, 1'b0);
        bus.fb_ready = 1'b1;
        bus.nb_ready = 1'b1;

        run_block(4, 4, 2, 21, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.x_valid = 1'b0;
        rst         = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_col", 32'(dut.col), 0);
        chk("midrst_row", 32'(dut.row), 0);
        chk("midrst_band", 32'(dut.band), 0);
        chk("midrst_done", 32'(block_done), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("postrst_done", 32'(block_done), 0);
        chk("postrst_busy", 32'(busy), 0);
        run_block(4, 4, 2, 32, 1'b0, 1'b0, 1'b0);

        run_block(2, 2, 2, 8, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        #1;
        chk("hold_accepted", 32'(busy), 1);
        run_block(2, 2, 2, 8, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
